// File: rtl/mlp_pkg.sv
// Shared types and helpers for the MLP weight bank.
// Holds the default weight width, index-width helper and FSM states.
package mlp_pkg;

    localparam int WEIGHT_W = 16;

    // Index width that never collapses to zero bits.
    function automatic int clog2f1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ST_IDLE,
        ST_STREAM
    } state_t;

endpackage

// File: rtl/mlp_weight_bank_if.sv
// Configuration write port and row-stream handshake of the weight bank.
// The master drives writes/start/ready; the slave is the bank itself.
interface mlp_weight_bank_if
    import mlp_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 8,
    parameter int W     = WEIGHT_W
) ();
    localparam int RW = clog2f1(N_OUT);
    localparam int CW = clog2f1(N_IN);

    logic              wr_en;
    logic [RW-1:0]     wr_row;
    logic [CW-1:0]     wr_col;
    logic [W-1:0]      wr_data;
    logic              wr_err;
    logic              start;
    logic              busy;
    logic              done;
    logic              row_valid;
    logic              row_ready;
    logic [RW-1:0]     row_idx;
    logic              row_last;
    logic [N_IN*W-1:0] row_w;

    modport master (
        output wr_en, wr_row, wr_col, wr_data,
        output start, row_ready,
        input  wr_err, busy, done,
        input  row_valid, row_idx, row_last, row_w
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_data,
        input  start, row_ready,
        output wr_err, busy, done,
        output row_valid, row_idx, row_last, row_w
    );

endinterface

// File: rtl/mlp_weight_regfile.sv
// Weight storage array with range-checked single-entry writes
// and a combinational full-row read by index.
module mlp_weight_regfile
    import mlp_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 8,
    parameter int W     = WEIGHT_W,
    parameter int RW    = clog2f1(N_OUT),
    parameter int CW    = clog2f1(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [RW-1:0]     wr_row,
    input  logic [CW-1:0]     wr_col,
    input  logic [W-1:0]      wr_data,
    output logic              wr_bad,
    input  logic [RW-1:0]     rd_idx,
    output logic [N_IN*W-1:0] rd_row
);
    localparam logic [RW:0] ROWS = (RW+1)'(N_OUT);
    localparam logic [CW:0] COLS = (CW+1)'(N_IN);

    logic [W-1:0] mem [N_OUT][N_IN];
    logic         in_range;

    assign in_range = ({1'b0, wr_row} < ROWS) && ({1'b0, wr_col} < COLS);
    assign wr_bad   = wr_en & ~in_range;

    // Decode per entry, so out-of-range indices simply match nothing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < N_OUT; r++)
                for (int c = 0; c < N_IN; c++)
                    mem[r][c] <= '0;
        end else begin
            for (int r = 0; r < N_OUT; r++)
                for (int c = 0; c < N_IN; c++)
                    if (wr_en && wr_row == RW'(r) && wr_col == CW'(c))
                        mem[r][c] <= wr_data;
        end
    end

    always_comb begin
        rd_row = '0;
        for (int r = 0; r < N_OUT; r++)
            if (rd_idx == RW'(r))
                for (int c = 0; c < N_IN; c++)
                    rd_row[c*W +: W] = mem[r][c];
    end

endmodule

// File: rtl/mlp_weight_bank.sv
// Run-time writable MLP layer weight bank; streams one neuron row
// per beat to the MAC array over a valid/ready handshake.
module mlp_weight_bank
    import mlp_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 8,
    parameter int W     = WEIGHT_W
) (
    input logic              clk,
    input logic              rst_n,
    mlp_weight_bank_if.slave bus
);
    localparam int RW = clog2f1(N_OUT);
    localparam int CW = clog2f1(N_IN);
    localparam logic [RW-1:0] LAST = RW'(N_OUT - 1);

    state_t            state;
    logic [RW-1:0]     nxt_idx;
    logic [N_IN*W-1:0] rd_row;
    logic              wr_bad;
    logic              beat;

    mlp_weight_regfile #(
        .N_IN  (N_IN),
        .N_OUT (N_OUT),
        .W     (W),
        .RW    (RW),
        .CW    (CW)
    ) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (bus.wr_en),
        .wr_row  (bus.wr_row),
        .wr_col  (bus.wr_col),
        .wr_data (bus.wr_data),
        .wr_bad  (wr_bad),
        .rd_idx  (nxt_idx),
        .rd_row  (rd_row)
    );

    assign beat    = bus.row_valid & bus.row_ready;
    assign nxt_idx = (state == ST_IDLE) ? '0 : bus.row_idx + RW'(1);

    // The output register samples pre-edge storage, so a same-edge
    // write to the loaded row lands only in the next stream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            bus.row_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.wr_err    <= 1'b0;
            bus.row_idx   <= '0;
            bus.row_last  <= 1'b0;
            bus.row_w     <= '0;
        end else begin
            bus.done   <= 1'b0;
            bus.wr_err <= wr_bad;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state         <= ST_STREAM;
                        bus.row_valid <= 1'b1;
                        bus.busy      <= 1'b1;
                        bus.row_w     <= rd_row;
                        bus.row_idx   <= nxt_idx;
                        bus.row_last  <= (nxt_idx == LAST);
                    end
                end
                ST_STREAM: begin
                    if (beat) begin
                        if (bus.row_last) begin
                            state         <= ST_IDLE;
                            bus.row_valid <= 1'b0;
                            bus.busy      <= 1'b0;
                            bus.done      <= 1'b1;
                        end else begin
                            bus.row_w    <= rd_row;
                            bus.row_idx  <= nxt_idx;
                            bus.row_last <= (nxt_idx == LAST);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_weight_bank.sv
// Scoreboard bench for mlp_weight_bank: random and directed traffic
// checked against a matrix-level reference model.
module tb_mlp_weight_bank;
    import mlp_pkg::*;

    localparam int NI = 4;
    localparam int NO = 8;
    localparam int WW = 16;
    localparam int RW = 3;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mlp_weight_bank_if #(.N_IN(NI), .N_OUT(NO), .W(WW)) bus ();
    mlp_weight_bank_if #(.N_IN(3), .N_OUT(6), .W(WW)) bus6 ();

    mlp_weight_bank #(.N_IN(NI), .N_OUT(NO), .W(WW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    mlp_weight_bank #(.N_IN(3), .N_OUT(6), .W(WW)) dut6 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus6)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input bit ok, input string nm,
                       input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int                 idx;
        bit                 last;
        logic [NI*WW-1:0]   w;
    } item_t;

    logic [WW-1:0] ref_w [NO][NI];
    item_t exp_q[$];
    bit m_busy = 0;
    bit m_done = 0;
    int m_cur  = 0;

    function automatic logic [NI*WW-1:0] pack_row(input int r);
        logic [NI*WW-1:0] v;
        for (int c = 0; c < NI; c++) v[c*WW +: WW] = ref_w[r][c];
        return v;
    endfunction

    function automatic void push_row(input int r);
        item_t it;
        it.idx  = r;
        it.last = (r == NO - 1);
        it.w    = pack_row(r);
        exp_q.push_back(it);
    endfunction

    function automatic void model_clear();
        for (int r = 0; r < NO; r++)
            for (int c = 0; c < NI; c++) ref_w[r][c] = '0;
        exp_q.delete();
        m_busy = 0;
        m_done = 0;
        m_cur  = 0;
    endfunction

    // Reference: a row is snapshotted from the matrix when it is loaded,
    // before that edge's write is applied.
    initial forever begin
        @(posedge clk);
        if (rst_n) begin
            if (!m_busy) begin
                m_done = 0;
                if (bus.start) begin
                    m_busy = 1;
                    m_cur  = 0;
                    push_row(0);
                end
            end else if (bus.row_ready) begin
                if (m_cur == NO - 1) begin
                    m_busy = 0;
                    m_done = 1;
                end else begin
                    m_cur++;
                    push_row(m_cur);
                end
            end
            if (bus.wr_en && int'(bus.wr_row) < NO && int'(bus.wr_col) < NI)
                ref_w[bus.wr_row][bus.wr_col] = bus.wr_data;
        end
    end

    // Monitor
    initial forever begin
        item_t it;
        @(negedge clk);
        if (rst_n) begin
            chk(bus.busy == m_busy, "busy", 64'(bus.busy), 64'(m_busy));
            chk(bus.done == m_done, "done", 64'(bus.done), 64'(m_done));
            chk(bus.row_valid == m_busy, "row_valid",
                64'(bus.row_valid), 64'(m_busy));
            if (bus.row_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected row", 64'(bus.row_idx), 64'(0));
                end else begin
                    it = exp_q[0];
                    chk(int'(bus.row_idx) == it.idx, "row_idx",
                        64'(bus.row_idx), 64'(it.idx));
                    chk(bus.row_last == it.last, "row_last",
                        64'(bus.row_last), 64'(it.last));
                    chk(bus.row_w == it.w, "row_w", bus.row_w, it.w);
                    if (bus.row_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wr(input int r, input int c, input int d);
        bus.wr_en   = 1'b1;
        bus.wr_row  = RW'(r);
        bus.wr_col  = CW'(c);
        bus.wr_data = WW'(d);
        step();
        bus.wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 500) begin
            step();
            n++;
        end
        if (bus.busy) chk(1'b0, "idle timeout", 64'(n), 64'(500));
    endtask

    task automatic stream_full(output int beats,
                               output logic [NI*WW-1:0] first_w,
                               output logic [NI*WW-1:0] last_w);
        bus.row_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        beats   = 0;
        first_w = bus.row_w;
        last_w  = '0;
        while (bus.busy && beats < 100) begin
            if (bus.row_last) last_w = bus.row_w;
            beats++;
            step();
        end
    endtask

    initial begin
        int b;
        int n;
        logic [NI*WW-1:0] fw, lw, held;
        logic [47:0] e6;

        bus.wr_en = 0; bus.wr_row = '0; bus.wr_col = '0; bus.wr_data = '0;
        bus.start = 0; bus.row_ready = 0;
        bus6.wr_en = 0; bus6.wr_row = '0; bus6.wr_col = '0;
        bus6.wr_data = '0; bus6.start = 0; bus6.row_ready = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #2;
        chk(bus.row_valid == 0, "rst row_valid", 64'(bus.row_valid), 0);
        chk(bus.busy == 0, "rst busy", 64'(bus.busy), 0);
        chk(bus.done == 0, "rst done", 64'(bus.done), 0);
        chk(bus.wr_err == 0, "rst wr_err", 64'(bus.wr_err), 0);
        chk(bus.row_idx == 0, "rst row_idx", 64'(bus.row_idx), 0);
        chk(bus.row_last == 0, "rst row_last", 64'(bus.row_last), 0);
        chk(bus.row_w == 0, "rst row_w", bus.row_w, 0);
        rst_n = 1'b1;
        step();

        // All-zero stream after reset
        stream_full(b, fw, lw);
        chk(b == NO, "zero beats", 64'(b), 64'(NO));
        step();

        // Load r*4+c+1 plus two corner values in row 0
        for (int r = 0; r < NO; r++)
            for (int c = 0; c < NI; c++) wr(r, c, r * 4 + c + 1);
        wr(0, 0, 28366);
        wr(0, 1, -32768);
        stream_full(b, fw, lw);
        chk(b == NO, "load beats", 64'(b), 64'(NO));
        chk(fw == 64'h0004_0003_8000_6ece, "row0 packed", fw,
            64'h0004_0003_8000_6ece);
        chk(lw == 64'h0020_001f_001e_001d, "row7 packed", lw,
            64'h0020_001f_001e_001d);
        step();

        // Backpressure on row 2 with a write to it and a stray start
        bus.row_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (!(bus.row_valid && bus.row_idx == 2) && n < 50) begin
            step();
            n++;
        end
        held = bus.row_w;
        bus.row_ready = 1'b0;
        bus.start     = 1'b1;
        wr(2, 0, -1);
        bus.start = 1'b0;
        step();
        step();
        chk(bus.row_w == held, "bp held", bus.row_w, held);
        chk(bus.row_idx == 2, "bp idx", 64'(bus.row_idx), 2);
        bus.row_ready = 1'b1;
        wait_idle();
        step();
        stream_full(b, fw, lw);
        step();

        // Write into row 3 on the edge that loads it
        bus.row_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        wr(3, 1, 12345);
        wait_idle();
        step();
        stream_full(b, fw, lw);
        step();

        // Out-of-range writes on a 6x3 build
        bus6.wr_en = 1; bus6.wr_row = 3'd5; bus6.wr_col = 2'd2;
        bus6.wr_data = 16'd7;
        step();
        bus6.wr_row = 3'd6; bus6.wr_col = 2'd0; bus6.wr_data = 16'd99;
        chk(bus6.wr_err == 0, "err after good wr", 64'(bus6.wr_err), 0);
        step();
        bus6.wr_row = 3'd0; bus6.wr_col = 2'd3; bus6.wr_data = 16'd55;
        chk(bus6.wr_err == 1, "err row oob", 64'(bus6.wr_err), 1);
        step();
        bus6.wr_en = 0;
        chk(bus6.wr_err == 1, "err col oob", 64'(bus6.wr_err), 1);
        step();
        chk(bus6.wr_err == 0, "err pulse ends", 64'(bus6.wr_err), 0);
        bus6.row_ready = 1'b1;
        bus6.start     = 1'b1;
        step();
        bus6.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e6 = (i == 5) ? 48'h0007_0000_0000 : 48'h0;
            chk(bus6.row_valid == 1, "n6 valid", 64'(bus6.row_valid), 1);
            chk(int'(bus6.row_idx) == i, "n6 idx",
                64'(bus6.row_idx), 64'(i));
            chk(bus6.row_last == (i == 5), "n6 last",
                64'(bus6.row_last), 64'(i == 5));
            chk(bus6.row_w == e6, "n6 row_w", 64'(bus6.row_w), 64'(e6));
            step();
        end
        chk(bus6.done == 1, "n6 done", 64'(bus6.done), 1);
        chk(bus6.busy == 0, "n6 busy", 64'(bus6.busy), 0);
        bus6.row_ready = 1'b0;
        step();

        // Random traffic
        for (int k = 0; k < 400; k++) begin
            bus.wr_en     = ($urandom_range(0, 9) < 3);
            bus.wr_row    = RW'($urandom);
            bus.wr_col    = CW'($urandom);
            bus.wr_data   = WW'($urandom);
            bus.row_ready = ($urandom_range(0, 9) < 7);
            bus.start     = ($urandom_range(0, 9) == 0);
            step();
        end
        bus.wr_en = 0;
        bus.start = 0;
        bus.row_ready = 1'b1;
        wait_idle();
        step();

        // Reset in the middle of a stream
        bus.row_ready = 1'b1;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (!(bus.row_valid && bus.row_idx == 4) && n < 50) begin
            step();
            n++;
        end
        rst_n = 1'b0;
        model_clear();
        #1;
        chk(bus.row_valid == 0, "mid rst valid", 64'(bus.row_valid), 0);
        chk(bus.busy == 0, "mid rst busy", 64'(bus.busy), 0);
        chk(bus.done == 0, "mid rst done", 64'(bus.done), 0);
        step();
        rst_n = 1'b1;
        step();
        stream_full(b, fw, lw);
        chk(b == NO, "post rst beats", 64'(b), 64'(NO));
        step();
        step();

        chk(exp_q.size() == 0, "queue drained", 64'(exp_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
